pwm_duty_decoder: RTL
=====================

Name: pwm_duty_decoder

Overview:
Receive-side counterpart of the PWM generator. It samples an asynchronous PWM line and measures the period and high time between consecutive rising edges. It converts the ratio to a duty step of 0..10, where each step is 10 %, matching the generator's step size. It flags a stuck line (constant 0 % or 100 %) and measurement overruns. It is used for loopback self-test of the PWM generator and for decoding external PWM sensors.

Parameters:
CNT_W, 16, width of period/high counters and outputs
TIMEOUT_CYC, 65535, cycles without a rising edge before the line is declared stuck; must be at most 2^CNT_W-1 and at least 16

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous active-high reset
pwm_in  in  1  asynchronous PWM input
period  out  CNT_W  last measured period in clk cycles (0 when stuck)
high_time  out  CNT_W  last measured high cycles
duty_step  out  4  rounded duty, 0..10
valid  out  1  one-cycle pulse: period/high_time/duty_step updated this cycle
stuck  out  1  high while the line is declared stuck
overrun  out  1  sticky: a period closed while the divider was busy

Behaviour:
- Input path: 2-FF synchronizer (s1, s2), then delay reg s3; rise = s2 & ~s3. No debounce.
- Reset: all outputs 0, counters 0, synchronizer regs 0, FSM to SEEK, divider idle. The same applies when rst is asserted mid-measurement or mid-divide; in-flight results are discarded and valid does not pulse.
- FSM SEEK: counters held at 0. On rise go to MEAS, with per_cnt=1 and hi_cnt=1 (the rise cycle counts as high).
- FSM MEAS, each cycle without rise: per_cnt+=1; hi_cnt+=1 if s2=1. Both saturate at TIMEOUT_CYC.
- FSM MEAS, on rise: per_cnt/hi_cnt are copied to capture regs, the divider starts (if idle), per_cnt=1, hi_cnt=1, stay in MEAS. Measurement is continuous, with one result per period.
- Timeout: per_cnt reaches TIMEOUT_CYC in MEAS, or SEEK lasts TIMEOUT_CYC cycles. Then go to SEEK, set stuck=1, period=0, high_time=0, duty_step = 10 if s2=1 else 0, and valid pulses once.
- stuck clears on the next rise. The first full period afterwards produces a normal result.
- Divider: duty_step = floor((20*hi + per) / (2*per)), i.e. round-half-up of 10*hi/per.
  - Numerator width is CNT_W+5; quotient is 4 bits.
  - Restoring, one quotient bit per cycle, MSB first.
  - Rise detected in cycle E: capture at E. Iterations run at E+1..E+4. Outputs are registered and valid=1 at E+5.
  - Quotient is clamped to 10.
- Overrun: a rise while the divider is busy (period < 5 cycles) sets overrun (sticky until rst). That capture is discarded; the in-flight result completes normally.
- Simultaneous timeout and valid cannot occur, since TIMEOUT_CYC >= 16. If a divider completion and a timeout land in the same cycle, the timeout values win and valid pulses once.
- Latency from a pwm_in rising edge to valid: 3 cycles to detect the closing rise, plus 5 cycles.

Test Plan:
- Generator pattern, period 10 and high 5, repeated 4 periods -> first valid after the 2nd rise; then period=10, high_time=5, duty_step=5, and valid pulses every 10 cycles.
- Period 10, high 3, then a switch to high 9 -> duty_step=3, then duty_step=9 on the first period fully at 9. The transitional period reports its actual high count.
- Rounding: period 7/high 2 -> duty_step=3; period 20/high 1 -> 1 (half rounds up); period 20/high 19 -> 10.
- pwm_in held 0 for TIMEOUT_CYC (set 32 for sim) -> stuck=1, duty_step=0, period=0, single valid. Then held 1 -> remains stuck until a rise; after a normal waveform resumes, stuck=0 and a correct result follows.
- Period 4 (high 2) stream -> overrun=1 and stays set. Reported results stay consistent (period=4, duty_step=5) at a reduced rate.
- rst pulsed 2 cycles after a closing rise -> no valid, all outputs 0. The FSM returns to SEEK and the next result appears only after two further rises.

Source files
------------

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder
// Measures period and high time of an asynchronous PWM line between
// consecutive rising edges and converts the ratio into a rounded duty
// step of 0..10 (10 % per step). It also flags a stuck line and
// measurement overruns, for generator loopback and external PWM sensors.
module pwm_duty_decoder #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [3:0]       duty_step,
    output logic             valid,
    output logic             stuck,
    output logic             overrun
);

    localparam int NUM_W = CNT_W + 5;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_SAT = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_M1  = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [0:0] {
        ST_SEEK = 1'b0,
        ST_MEAS = 1'b1
    } state_t;

    // Numerator of the rounding division: 20*hi + per.
    function automatic logic [NUM_W-1:0] duty_numer(input logic [CNT_W-1:0] per,
                                                    input logic [CNT_W-1:0] hi);
        duty_numer = (NUM_W'(hi) << 4) + (NUM_W'(hi) << 2) + NUM_W'(per);
    endfunction

    // Denominator of the rounding division: 2*per.
    function automatic logic [NUM_W-1:0] duty_denom(input logic [CNT_W-1:0] per);
        duty_denom = NUM_W'({per, 1'b0});
    endfunction

    logic             s1_r;
    logic             s2_r;
    logic             s3_r;
    logic             rise_s;

    state_t           state_r;
    state_t           next_state_s;
    logic             timeout_s;
    logic             capture_s;
    logic             start_s;
    logic             ovr_hit_s;

    logic [CNT_W-1:0] per_cnt_r;
    logic [CNT_W-1:0] hi_cnt_r;
    logic [CNT_W-1:0] seek_cnt_r;

    logic             busy_r;
    logic [1:0]       iter_r;
    logic [NUM_W-1:0] rem_r;
    logic [NUM_W-1:0] den_r;
    logic [3:0]       quo_r;
    logic [CNT_W-1:0] cap_per_r;
    logic [CNT_W-1:0] cap_hi_r;

    logic [NUM_W-1:0] trial_s;
    logic             bit_s;
    logic [NUM_W-1:0] rem_next_s;
    logic [3:0]       quo_next_s;
    logic [3:0]       quo_clamp_s;
    logic             done_s;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= pwm_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign rise_s = s2_r & ~s3_r;

    // Measurement FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_SEEK;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state and timeout detection; a stuck line suppresses repeated SEEK timeouts.
    always_comb begin
        next_state_s = state_r;
        timeout_s    = 1'b0;
        case (state_r)
            ST_SEEK: begin
                if (rise_s) begin
                    next_state_s = ST_MEAS;
                end else if (!stuck && (seek_cnt_r >= TIMEOUT_M1)) begin
                    next_state_s = ST_SEEK;
                    timeout_s    = 1'b1;
                end else begin
                    next_state_s = ST_SEEK;
                end
            end
            ST_MEAS: begin
                if (rise_s) begin
                    next_state_s = ST_MEAS;
                end else if (per_cnt_r >= TIMEOUT_M1) begin
                    next_state_s = ST_SEEK;
                    timeout_s    = 1'b1;
                end else begin
                    next_state_s = ST_MEAS;
                end
            end
            default: begin
                next_state_s = ST_SEEK;
                timeout_s    = 1'b0;
            end
        endcase
    end

    assign capture_s = (state_r == ST_MEAS) & rise_s;
    assign start_s   = capture_s & ~busy_r;
    assign ovr_hit_s = capture_s & busy_r;

    // Period/high counters; the rise cycle itself counts as the first high cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt_r <= '0;
            hi_cnt_r  <= '0;
        end else if (rise_s) begin
            per_cnt_r <= CNT_ONE;
            hi_cnt_r  <= CNT_ONE;
        end else if ((state_r == ST_MEAS) && !timeout_s) begin
            per_cnt_r <= (per_cnt_r < TIMEOUT_SAT) ? per_cnt_r + CNT_ONE : per_cnt_r;
            if (s2_r && (hi_cnt_r < TIMEOUT_SAT)) begin
                hi_cnt_r <= hi_cnt_r + CNT_ONE;
            end else begin
                hi_cnt_r <= hi_cnt_r;
            end
        end else begin
            per_cnt_r <= '0;
            hi_cnt_r  <= '0;
        end
    end

    // Cycles spent in SEEK without a rise, saturating at the timeout threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            seek_cnt_r <= '0;
        end else if ((state_r == ST_SEEK) && !rise_s) begin
            seek_cnt_r <= (seek_cnt_r < TIMEOUT_M1) ? seek_cnt_r + CNT_ONE : seek_cnt_r;
        end else begin
            seek_cnt_r <= '0;
        end
    end

    // One restoring step: try subtracting the denominator aligned to the current quotient bit.
    always_comb begin
        trial_s     = den_r << iter_r;
        bit_s       = (rem_r >= trial_s);
        rem_next_s  = rem_r;
        quo_next_s  = quo_r;
        if (bit_s) begin
            rem_next_s = rem_r - trial_s;
        end else begin
            rem_next_s = rem_r;
        end
        quo_next_s[iter_r] = bit_s;
        if (quo_next_s > 4'd10) begin
            quo_clamp_s = 4'd10;
        end else begin
            quo_clamp_s = quo_next_s;
        end
    end

    assign done_s = busy_r & (iter_r == 2'd0);

    // Divider sequencing: load on capture, four MSB-first iterations, then idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r    <= 1'b0;
            iter_r    <= 2'd0;
            rem_r     <= '0;
            den_r     <= '0;
            quo_r     <= 4'd0;
            cap_per_r <= '0;
            cap_hi_r  <= '0;
        end else if (start_s) begin
            busy_r    <= 1'b1;
            iter_r    <= 2'd3;
            rem_r     <= duty_numer(per_cnt_r, hi_cnt_r);
            den_r     <= duty_denom(per_cnt_r);
            quo_r     <= 4'd0;
            cap_per_r <= per_cnt_r;
            cap_hi_r  <= hi_cnt_r;
        end else if (busy_r) begin
            rem_r  <= rem_next_s;
            quo_r  <= quo_next_s;
            iter_r <= iter_r - 2'd1;
            busy_r <= ~done_s;
        end else begin
            busy_r <= 1'b0;
        end
    end

    // Result registers; a timeout takes priority over a completing division.
    always_ff @(posedge clk) begin
        if (rst) begin
            period    <= '0;
            high_time <= '0;
            duty_step <= 4'd0;
            valid     <= 1'b0;
        end else if (timeout_s) begin
            period    <= '0;
            high_time <= '0;
            duty_step <= s2_r ? 4'd10 : 4'd0;
            valid     <= 1'b1;
        end else if (done_s) begin
            period    <= cap_per_r;
            high_time <= cap_hi_r;
            duty_step <= quo_clamp_s;
            valid     <= 1'b1;
        end else begin
            valid     <= 1'b0;
        end
    end

    // Stuck flag: set by a timeout, cleared by the next rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            stuck <= 1'b0;
        end else if (timeout_s) begin
            stuck <= 1'b1;
        end else if (rise_s) begin
            stuck <= 1'b0;
        end else begin
            stuck <= stuck;
        end
    end

    // Sticky overrun: a period closed while the divider was still working.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (ovr_hit_s) begin
            overrun <= 1'b1;
        end else begin
            overrun <= overrun;
        end
    end

endmodule
